// File: rtl/emtf_axil_cmd_master.sv
// Single-outstanding command-to-AXI4-Lite bridge: turns one cmd-channel request into one
// AXI4-Lite read or write and returns the result, aborting on a slave that never answers.
`timescale 1ns/1ps
module emtf_axil_cmd_master #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES     = 256
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  // command channel
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_we,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response channel
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_timeout,
  // AXI4-Lite master
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam logic [15:0] WaitLimit = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdResp,
    StRsp
  } state_e;

  state_e                          state;
  logic [15:0]                     wait_cnt;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr;
  logic                            waiting;
  logic                            done;
  logic                            abort;

  assign cmd_ready    = (state == StIdle) && !ARESET;
  assign M_AXI_AWADDR = addr;
  assign M_AXI_ARADDR = addr;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  assign waiting = (state == StWrReq) || (state == StWrResp) ||
                   (state == StRdReq) || (state == StRdResp);

  // A channel whose valid has already dropped has completed its handshake.
  always_comb begin
    done = 1'b0;
    case (state)
      StWrReq:  done = (!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY);
      StWrResp: done = M_AXI_BVALID;
      StRdReq:  done = M_AXI_ARREADY;
      StRdResp: done = M_AXI_RVALID;
      default:  done = 1'b0;
    endcase
  end

  // Completion in the limit cycle wins over the abort.
  assign abort = waiting && !done && (wait_cnt >= WaitLimit);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state         <= StIdle;
      wait_cnt      <= '0;
      addr          <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      rsp_timeout   <= 1'b0;
    end else begin
      if (waiting) wait_cnt <= wait_cnt + 16'd1;

      case (state)
        StIdle: begin
          if (cmd_valid) begin
            addr        <= cmd_addr;
            M_AXI_WDATA <= cmd_wdata;
            M_AXI_WSTRB <= cmd_wstrb;
            wait_cnt    <= '0;
            if (cmd_we) begin
              state         <= StWrReq;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
            end else begin
              state         <= StRdReq;
              M_AXI_ARVALID <= 1'b1;
            end
          end
        end
        StWrReq: begin
          if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
          if (done) begin
            state        <= StWrResp;
            M_AXI_BREADY <= 1'b1;
          end
        end
        StWrResp: begin
          if (M_AXI_BVALID) begin
            state        <= StRsp;
            M_AXI_BREADY <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_resp     <= M_AXI_BRESP;
            rsp_rdata    <= '0;
            rsp_timeout  <= 1'b0;
          end
        end
        StRdReq: begin
          if (M_AXI_ARREADY) begin
            state         <= StRdResp;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
          end
        end
        StRdResp: begin
          if (M_AXI_RVALID) begin
            state        <= StRsp;
            M_AXI_RREADY <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_resp     <= M_AXI_RRESP;
            rsp_rdata    <= M_AXI_RDATA;
            rsp_timeout  <= 1'b0;
          end
        end
        StRsp: begin
          if (rsp_ready) begin
            state     <= StIdle;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase

      // Dead-slave recovery: drop every AXI handshake signal and report a timeout.
      if (abort) begin
        state         <= StRsp;
        M_AXI_AWVALID <= 1'b0;
        M_AXI_WVALID  <= 1'b0;
        M_AXI_BREADY  <= 1'b0;
        M_AXI_ARVALID <= 1'b0;
        M_AXI_RREADY  <= 1'b0;
        rsp_valid     <= 1'b1;
        rsp_resp      <= 2'b10;
        rsp_rdata     <= '0;
        rsp_timeout   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/emtf_axil_cmd_master.md
EMTF_AXIL_CMD_MASTER -- requirements
Module: emtf_axil_cmd_master

Interface
REQ-001 The block SHALL run on one clock; reset SHALL be asynchronous and active-high.
REQ-002 Parameter C_M_AXI_ADDR_WIDTH SHALL default to 32 and set the AXI4-Lite address width.
REQ-003 Parameter C_M_AXI_DATA_WIDTH SHALL default to 32 and set the data width (strobe width = DATA/8).
REQ-004 Parameter TIMEOUT_CYCLES SHALL default to 256 and set the wait-state cycle limit.
REQ-005 Port ACLK, input, 1 bit, SHALL be the clock.
REQ-006 Port ARESET, input, 1 bit, SHALL be the reset.
REQ-007 Ports cmd_valid (in, 1), cmd_ready (out, 1), cmd_we (in, 1), cmd_addr (in, ADDR), cmd_wdata (in, DATA), cmd_wstrb (in, DATA/8) SHALL form the command channel.
REQ-008 Ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_rdata (out, DATA), rsp_resp (out, 2), rsp_timeout (out, 1) SHALL form the response channel.
REQ-009 Ports M_AXI_AW{ADDR,PROT,VALID,READY}, M_AXI_W{DATA,STRB,VALID,READY}, M_AXI_B{RESP,VALID,READY}, M_AXI_AR{ADDR,PROT,VALID,READY} and M_AXI_R{DATA,RESP,VALID,READY} SHALL form a standard AXI4-Lite master port toward the register bank.

Function
REQ-010 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
REQ-011 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid & cmd_ready.
REQ-012 On accept, address, data, strobe and direction SHALL be registered; next state is WR_REQ if cmd_we=1, else RD_REQ.
REQ-013 In WR_REQ, AWVALID and WVALID SHALL assert together one cycle after accept; each SHALL drop independently on its own handshake, and the FSM SHALL move to WR_RESP once both have completed, in either order or in the same cycle.
REQ-014 In WR_RESP, BREADY SHALL be 1; on BVALID the block SHALL capture BRESP into rsp_resp, set rsp_rdata=0, and go to RSP.
REQ-015 In RD_REQ, ARVALID SHALL assert until ARREADY, then the FSM SHALL go to RD_RESP.
REQ-016 In RD_RESP, RREADY SHALL be 1; on RVALID the block SHALL capture RDATA and RRESP, then go to RSP.
REQ-017 AWPROT and ARPROT SHALL be constant 3'b000.
REQ-018 In RSP, rsp_valid SHALL be 1 with stable payload until rsp_ready; on that handshake the FSM SHALL return to IDLE.
REQ-019 Only one transaction SHALL be outstanding at a time.
REQ-020 With a zero-wait slave, accept-to-rsp_valid latency SHALL be 3 cycles.
REQ-021 A 16-bit wait counter SHALL clear on entry to WR_REQ/RD_REQ and increment each cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
REQ-022 When the counter reaches TIMEOUT_CYCLES-1 without completion, all AXI valid/ready outputs SHALL deassert next cycle, and the FSM SHALL go to RSP with rsp_resp=2'b10, rsp_timeout=1 and rsp_rdata=0. This deliberate protocol abort is the recovery path for a dead slave.
REQ-023 rsp_timeout SHALL be 0 for every normally completed transaction.
REQ-024 A handshake occurring in the same cycle as the timeout limit SHALL take priority, and no timeout SHALL be flagged.
REQ-025 SLVERR/DECERR from the slave SHALL be passed through unchanged in rsp_resp.

Reset
REQ-026 While ARESET=1, the FSM SHALL be IDLE and all valid/ready outputs, rsp_* outputs and the counter SHALL be 0, except cmd_ready, which SHALL be 1 once ARESET deasserts.
REQ-027 Reset asserted mid-transaction SHALL abandon it immediately with no response generated; the first command after reset SHALL behave normally.

Verification
REQ-028 Write cmd addr 0x0, data 0x00000001, wstrb 0xF, to a zero-wait register bank -> one AW/W handshake at 0x0, rsp_valid after 3 cycles, rsp_resp=0, rsp_timeout=0.
REQ-029 Writes of 0x1..0x4 to 0x0,0x4,0x8,0xC, then reads of the same addresses -> rsp_rdata equals 0x1,0x2,0x3,0x4 in order.
REQ-030 AWREADY delayed 3 cycles with WREADY immediate -> WVALID high 1 cycle, AWVALID high 4 cycles, exactly one B handshake, correct response.
REQ-031 Read with RVALID never asserted -> RREADY drops after 256 wait cycles, rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0; a following read to a live slave succeeds.
REQ-032 rsp_ready held low for 10 cycles -> rsp_valid and payload stable, cmd_ready=0 throughout, and a command presented meanwhile is not accepted.
REQ-033 ARESET pulsed while in WR_RESP -> all outputs 0 during reset, no rsp_valid, and the next read completes normally.
